quad_step_decoder: RTL

Upstream stage of the up/down position counter. Turns two asynchronous quadrature inputs (A, B) from a rotary encoder into a one-cycle count-enable pulse (`step`) and a direction level (`upcnt`). The counter consumes these directly, counting only on cycles where `step` is high. The block synchronises and glitch-filters both channels, decodes legal Gray transitions, and flags and counts illegal (two-bit) transitions.

---
 rtl/quad_step_decoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature encoder front end producing step/direction pulses and error tracking
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   a_in     encoder channel A (asynchronous)
//   b_in     encoder channel B (asynchronous)
//   clr_err  synchronous clear of err_cnt (wins over a coincident increment)
//   step     one-cycle pulse per legal quadrature edge
//   upcnt    direction of the last legal edge (1 = up)
//   err      one-cycle pulse per illegal two-bit transition
//   err_cnt  saturating count of illegal transitions
//   ready    high once the decoder has left its settle phase
module quad_step_decoder #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       clr_err,
    output logic       step,
    output logic       upcnt,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic       ready
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [3:0] C_MAX = 4'(FILT_LEN - 1);

    // Channel vectors are {A, B} throughout
    logic [1:0]      s1_q, s1_d, s2_q, s2_d, f_q, f_d, prev_q, prev_d;
    logic [1:0][3:0] c_q, c_d;
    logic [1:0]      init_cnt_q, init_cnt_d;
    state_t          state_q, state_d;
    logic            step_q, step_d, upcnt_q, upcnt_d, err_q, err_d, ready_q, ready_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [1:0]      delta;

    // One changed bit is a legal Gray step, both changed is an illegal jump
    assign delta = f_q ^ prev_q;

    always_comb begin
        s1_d       = {a_in, b_in};
        s2_d       = s1_q;
        f_d        = f_q;
        c_d        = c_q;
        prev_d     = prev_q;
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        step_d     = 1'b0;
        err_d      = 1'b0;
        upcnt_d    = upcnt_q;
        err_cnt_d  = err_cnt_q;
        if (state_q == INIT) begin
            // Track the pins so RUN starts with prev == cur and no false error
            f_d        = s2_q;
            prev_d     = s2_q;
            c_d        = '0;
            init_cnt_d = init_cnt_q + 2'd1;
            state_d    = (init_cnt_q == 2'd2) ? RUN : INIT;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == f_q[i]) begin
                    c_d[i] = '0;
                end else if (c_q[i] == C_MAX) begin
                    f_d[i] = s2_q[i];
                    c_d[i] = '0;
                end else begin
                    c_d[i] = c_q[i] + 4'd1;
                end
            end
            prev_d = f_q;
            step_d = ^delta;
            err_d  = &delta;
            // Up order is 00,10,11,01: an A change lands on A!=B, a B change on A==B
            if (step_d)
                upcnt_d = delta[1] ? (f_q[1] ^ f_q[0]) : ~(f_q[1] ^ f_q[0]);
            err_cnt_d = clr_err ? 8'd0 :
                        (err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        end
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            f_q        <= '0;
            c_q        <= '0;
            prev_q     <= '0;
            init_cnt_q <= '0;
            state_q    <= INIT;
            step_q     <= 1'b0;
            upcnt_q    <= 1'b1;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            ready_q    <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            f_q        <= f_d;
            c_q        <= c_d;
            prev_q     <= prev_d;
            init_cnt_q <= init_cnt_d;
            state_q    <= state_d;
            step_q     <= step_d;
            upcnt_q    <= upcnt_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            ready_q    <= ready_d;
        end
    end

    assign step    = step_q;
    assign upcnt   = upcnt_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign ready   = ready_q;
endmodule
